// File: rtl/alarm_pkg.sv
// Purpose: shared state type and default timing constants for the alarm annunciator.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SOUNDING = 2'd1,
    TIMEOUT  = 2'd2
  } annunciator_state_t;

  // Default cycle counts, kept in step with the alarm controller's timing constants.
  localparam int DEF_BLINK_PERIOD_CYCLES = 8;
  localparam int DEF_BLINK_ON_CYCLES     = 2;
  localparam int DEF_SIREN_HALF_CYCLES   = 3;
  localparam int DEF_SIREN_MAX_CYCLES    = 20;
  localparam int DEF_CHIRP_CYCLES        = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/annunciator_timer.sv
// Purpose: cycle counter 0..LAST with synchronous clear and enable; wraps or saturates at LAST.
// Latency: count visible one clock after the enabling edge.
// Backpressure: none; free-running under clear/enable control.
module annunciator_timer #(
  parameter int WIDTH    = 4,
  parameter int LAST     = 7,
  parameter bit SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(LAST);

  logic [WIDTH-1:0] r_cnt;

  // Clear wins over enable; at LAST either hold (saturate) or restart from zero (wrap).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST_VAL) begin
        r_cnt <= SATURATE ? LAST_VAL : '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/alarm_annunciator.sv
// Purpose: drives status LED blink, tone-modulated time-limited siren; optional arm chirp (ALARM_ANNUNCIATOR_CHIRP_EN).
// Latency: input change sampled at edge N shows on the registered outputs after edge N+1.
// Backpressure: none; inputs are controller levels, outputs are free-running drive patterns.
module alarm_annunciator
  import alarm_pkg::*;
#(
  parameter int BLINK_PERIOD_CYCLES = DEF_BLINK_PERIOD_CYCLES,
  parameter int BLINK_ON_CYCLES     = DEF_BLINK_ON_CYCLES,
  parameter int SIREN_HALF_CYCLES   = DEF_SIREN_HALF_CYCLES,
`ifdef ALARM_ANNUNCIATOR_CHIRP_EN
  parameter int CHIRP_CYCLES        = DEF_CHIRP_CYCLES,
`endif
  parameter int SIREN_MAX_CYCLES    = DEF_SIREN_MAX_CYCLES
) (
  input  logic clock,
  input  logic systemReset,
  input  logic statusIndicator,
  input  logic siren,
  output logic statusLed,
  output logic sirenDrive,
  output logic sirenTimedOut
);

  localparam int BLINK_W = cnt_width(BLINK_PERIOD_CYCLES);
  localparam int TONE_W  = cnt_width(SIREN_HALF_CYCLES);
  localparam int DUR_W   = $clog2(SIREN_MAX_CYCLES);

  localparam logic [BLINK_W-1:0] BLINK_ON  = BLINK_W'(BLINK_ON_CYCLES);
  localparam logic [TONE_W-1:0]  TONE_LAST = TONE_W'(SIREN_HALF_CYCLES - 1);
  localparam logic [DUR_W-1:0]   DUR_LAST  = DUR_W'(SIREN_MAX_CYCLES - 1);

  annunciator_state_t r_state;
  annunciator_state_t w_state_nxt;

  logic r_stat_q;
  logic r_siren_q;
  logic r_led;
  logic r_drive;
  logic r_tmo;

  logic w_enter;
  logic w_sounding;
  logic w_tone_nxt;
  logic w_led_nxt;
  logic w_drive_nxt;
  logic w_tmo_nxt;

  logic [BLINK_W-1:0] w_blink_cnt;
  logic [TONE_W-1:0]  w_tone_cnt;
  logic [DUR_W-1:0]   w_dur_cnt;

  assign w_sounding = (r_state == SOUNDING);

`ifdef ALARM_ANNUNCIATOR_CHIRP_EN
  localparam int CHIRP_W = cnt_width(CHIRP_CYCLES);
  localparam logic [CHIRP_W-1:0] CHIRP_LAST = CHIRP_W'(CHIRP_CYCLES - 1);

  logic               r_stat_qq;
  logic               r_chirp_on;
  logic               w_chirp_load;
  logic               w_chirp_on_nxt;
  logic [CHIRP_W-1:0] w_chirp_cnt;

  // Previous armed level for edge detection, and the chirp-active flag.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      r_stat_qq  <= 1'b0;
      r_chirp_on <= 1'b0;
    end else begin
      r_stat_qq  <= r_stat_q;
      r_chirp_on <= w_chirp_on_nxt;
    end
  end

  annunciator_timer #(.WIDTH(CHIRP_W), .LAST(CHIRP_CYCLES - 1), .SATURATE(1'b1)) u_chirp (
    .i_clk(clock), .i_rst(systemReset), .i_clr(w_chirp_load), .i_en(r_chirp_on), .o_cnt(w_chirp_cnt)
  );
`endif

  // Register both controller levels once before any use.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      r_stat_q  <= 1'b0;
      r_siren_q <= 1'b0;
    end else begin
      r_stat_q  <= statusIndicator;
      r_siren_q <= siren;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the next values of every registered output, so outputs land with the state.
  always_comb begin
    w_state_nxt = r_state;
    w_tone_nxt  = 1'b0;
    case (r_state)
      IDLE:     if (r_siren_q) w_state_nxt = SOUNDING;
      SOUNDING: begin
        if (!r_siren_q)                  w_state_nxt = IDLE;
        else if (w_dur_cnt == DUR_LAST)  w_state_nxt = TIMEOUT;
      end
      TIMEOUT:  if (!r_siren_q) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase

    w_enter = (r_state != SOUNDING) && (w_state_nxt == SOUNDING);

    // Tone starts high on entry, then flips each time the half-period counter completes.
    if (w_enter) begin
      w_tone_nxt = 1'b1;
    end else if (w_state_nxt == SOUNDING) begin
      w_tone_nxt = (w_tone_cnt == TONE_LAST) ? ~r_drive : r_drive;
    end

    w_tmo_nxt = (w_state_nxt == TIMEOUT);
    // Siren activity forces the LED solid; blink counter keeps running underneath.
    w_led_nxt = (w_state_nxt != IDLE) || (r_stat_q && (w_blink_cnt < BLINK_ON));

`ifdef ALARM_ANNUNCIATOR_CHIRP_EN
    // Chirp only starts from IDLE, is aborted by sounding, and ignores a falling armed level.
    w_chirp_load   = r_stat_q && !r_stat_qq && (r_state == IDLE) && !w_enter;
    w_chirp_on_nxt = !w_enter && (w_chirp_load || (r_chirp_on && (w_chirp_cnt != CHIRP_LAST)));
    w_drive_nxt    = (w_state_nxt == SOUNDING) ? w_tone_nxt : w_chirp_on_nxt;
`else
    w_drive_nxt    = w_tone_nxt;
`endif
  end

  // Registered output drives.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      r_led   <= 1'b0;
      r_drive <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_led   <= w_led_nxt;
      r_drive <= w_drive_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  annunciator_timer #(.WIDTH(BLINK_W), .LAST(BLINK_PERIOD_CYCLES - 1), .SATURATE(1'b0)) u_blink (
    .i_clk(clock), .i_rst(systemReset), .i_clr(!r_stat_q), .i_en(r_stat_q), .o_cnt(w_blink_cnt)
  );

  annunciator_timer #(.WIDTH(TONE_W), .LAST(SIREN_HALF_CYCLES - 1), .SATURATE(1'b0)) u_tone (
    .i_clk(clock), .i_rst(systemReset), .i_clr(w_enter), .i_en(w_sounding), .o_cnt(w_tone_cnt)
  );

  annunciator_timer #(.WIDTH(DUR_W), .LAST(SIREN_MAX_CYCLES - 1), .SATURATE(1'b1)) u_dur (
    .i_clk(clock), .i_rst(systemReset), .i_clr(w_enter), .i_en(w_sounding), .o_cnt(w_dur_cnt)
  );

  assign statusLed     = r_led;
  assign sirenDrive    = r_drive;
  assign sirenTimedOut = r_tmo;

endmodule
